// File: rtl/button_mmio_pkg.sv
// Shared constants for the memory-mapped push buttons: word addresses decoded
// by the data memory and the default debounce window.
package button_mmio_pkg;

  localparam logic [31:0] UP_ADDR          = 32'h0000_1008;
  localparam logic [31:0] DOWN_ADDR        = 32'h0000_1010;
  localparam int          DB_LIMIT_DEFAULT = 250000;
  localparam int          DB_CNT_W_DEFAULT = 18;

endpackage

// File: rtl/btn_debounce.sv
// One button path: 2-FF synchronizer, stable-level debouncer and a registered
// pulse marking each accepted 0->1 change of the debounced level.
module btn_debounce #(
  parameter int DB_LIMIT = 250000,
  parameter int DB_CNT_W = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_LIMIT - 1);

  logic                sync1;
  logic                synced;
  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      synced <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync1  <= raw;
      synced <= sync1;
      rise   <= 1'b0;
      // Any return to the current level before the window ends drops the count.
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= synced;
        cnt   <= '0;
        rise  <= synced;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_mmio.sv
// Sticky, read-to-clear press flags for the up/down buttons seen by the CPU
// through the data memory.
module button_mmio
  import button_mmio_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DB_LIMIT = DB_LIMIT_DEFAULT,
  parameter int DB_CNT_W = DB_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up_raw,
  input  logic             btn_down_raw,
  input  logic             memread,
  input  logic [WIDTH-1:0] adr,
  output logic             up,
  output logic             down,
  output logic             up_level,
  output logic             down_level
);

  localparam logic [WIDTH-1:0] UP_A   = WIDTH'(UP_ADDR);
  localparam logic [WIDTH-1:0] DOWN_A = WIDTH'(DOWN_ADDR);

  logic up_rise;
  logic down_rise;

  btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_db_up (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_up_raw),
    .level (up_level),
    .rise  (up_rise)
  );

  btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_db_down (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_down_raw),
    .level (down_level),
    .rise  (down_rise)
  );

  // A press wins over a clearing read in the same cycle so no press is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up   <= 1'b0;
      down <= 1'b0;
    end else begin
      if (up_rise)
        up <= 1'b1;
      else if (memread && (adr == UP_A))
        up <= 1'b0;

      if (down_rise)
        down <= 1'b1;
      else if (memread && (adr == DOWN_A))
        down <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_mmio.sv
// Scoreboard bench for button_mmio: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_button_mmio;

  localparam int DBL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_up_raw;
  logic        btn_down_raw;
  logic        memread;
  logic [31:0] adr;
  logic        up, down, up_level, down_level;

  button_mmio #(.WIDTH(32), .DB_LIMIT(DBL), .DB_CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .memread      (memread),
    .adr          (adr),
    .up           (up),
    .down         (down),
    .up_level     (up_level),
    .down_level   (down_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bit order {up, down, up_level, down_level}
  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] mask;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   up_rises = 0;
  int   down_rises = 0;
  logic up_q = 1'b0;
  logic down_q = 1'b0;

  task automatic chk(input int off, input string name, input logic [3:0] mask, input logic [3:0] val);
    exp_t e;
    e.cyc = cyc + off; e.name = name; e.mask = mask; e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [3:0] cur;
    exp_t e;
    forever begin
      @(negedge clk);
      cur = {up, down, up_level, down_level};
      if (up && !up_q) up_rises++;
      if (down && !down_q) down_rises++;
      up_q = up;
      down_q = down;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.cyc < cyc) begin
          n_bad++;
          $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
        end else if ((cur & e.mask) !== (e.val & e.mask)) begin
          n_bad++;
          $display("FAIL %s @%0d: got {up,down,up_lvl,dn_lvl}=%b expected %b (mask %b)",
                   e.name, cyc, cur, e.val, e.mask);
        end
      end
    end
  end

  initial begin : stim
    int r0;
    reset = 1'b0; btn_up_raw = 1'b0; btn_down_raw = 1'b0; memread = 1'b0; adr = 32'h0;
    tick(3);
    chk(0, "reset_state", 4'b1111, 4'b0000);
    tick();
    reset = 1'b1;
    tick(3);

    // clean press on up
    btn_up_raw = 1'b1;
    chk(5, "press_pre_level", 4'b1111, 4'b0000);
    chk(6, "press_level",     4'b1111, 4'b0010);
    chk(7, "press_flag",      4'b1111, 4'b1010);
    tick(10);

    // reads of other address, memread low, then the up address
    memread = 1'b1; adr = 32'h0000_1010;
    chk(0, "read_other_during", 4'b1000, 4'b1000);
    chk(1, "read_other_after",  4'b1000, 4'b1000);
    tick();
    memread = 1'b0; adr = 32'h0000_1008;
    chk(1, "no_memread_after", 4'b1000, 4'b1000);
    tick();
    memread = 1'b1; adr = 32'h0000_1008;
    chk(0, "read_up_during", 4'b1000, 4'b1000);
    chk(1, "read_up_after",  4'b1000, 4'b0000);
    tick();
    memread = 1'b0;
    tick();

    // release produces no event
    r0 = up_rises;
    btn_up_raw = 1'b0;
    chk(5, "release_pre_level", 4'b0010, 4'b0010);
    chk(6, "release_level",     4'b1010, 4'b0000);
    chk(7, "release_no_flag",   4'b1000, 4'b0000);
    tick(10);
    chk_int("release_events", up_rises - r0, 0);

    // press and clearing read land on the same edge
    btn_up_raw = 1'b1;
    chk(7, "press_read_same", 4'b1010, 4'b1010);
    tick(6);
    memread = 1'b1; adr = 32'h0000_1008;
    tick();
    memread = 1'b0;
    chk(1, "press_read_hold", 4'b1000, 4'b1000);
    tick();
    memread = 1'b1;
    chk(0, "second_read_during", 4'b1000, 4'b1000);
    chk(1, "second_read_clear",  4'b1000, 4'b0000);
    tick();
    memread = 1'b0;
    tick(2);

    // two presses before any read collapse into one flag
    r0 = up_rises;
    btn_up_raw = 1'b0; tick(8);
    btn_up_raw = 1'b1; tick(8);
    btn_up_raw = 1'b0; tick(8);
    btn_up_raw = 1'b1; tick(8);
    chk(0, "two_press_flag", 4'b1010, 4'b1010);
    chk_int("two_press_events", up_rises - r0, 1);
    memread = 1'b1; adr = 32'h0000_1008;
    chk(1, "two_press_clear", 4'b1000, 4'b0000);
    tick();
    memread = 1'b0;
    tick(10);
    chk(0, "two_press_no_second", 4'b1000, 4'b0000);
    tick();
    chk_int("two_press_events_after", up_rises - r0, 1);

    // bouncing down button: 3-cycle highs are shorter than the window
    r0 = down_rises;
    for (int i = 0; i < 5; i++) begin
      btn_down_raw = 1'b1; tick(3);
      chk(0, "bounce_quiet", 4'b0101, 4'b0000);
      btn_down_raw = 1'b0; tick(2);
    end
    btn_down_raw = 1'b1;
    chk(5, "bounce_pre_level", 4'b0101, 4'b0000);
    chk(6, "bounce_level",     4'b0101, 4'b0001);
    chk(7, "bounce_flag",      4'b0101, 4'b0101);
    tick(10);
    chk_int("bounce_events", down_rises - r0, 1);
    memread = 1'b1; adr = 32'h0000_1010;
    chk(0, "read_down_during", 4'b0100, 4'b0100);
    chk(1, "read_down_after",  4'b0100, 4'b0000);
    tick();
    memread = 1'b0;
    tick();

    // set down flag again, then reset mid-debounce of up with button held
    btn_up_raw = 1'b0; btn_down_raw = 1'b0; tick(8);
    btn_down_raw = 1'b1; tick(9);
    btn_up_raw = 1'b1;
    chk(0, "pre_reset_down", 4'b0100, 4'b0100);
    tick(3);
    reset = 1'b0;
    chk(0, "reset_async", 4'b1111, 4'b0000);
    tick(3);
    chk(0, "reset_hold", 4'b1111, 4'b0000);
    r0 = up_rises;
    reset = 1'b1;
    chk(5, "held_pre_level", 4'b1111, 4'b0000);
    chk(6, "held_level",     4'b1111, 4'b0011);
    chk(7, "held_flag",      4'b1111, 4'b1111);
    tick(10);
    chk_int("held_events", up_rises - r0, 1);
    memread = 1'b1; adr = 32'h0000_1008;
    chk(1, "held_clear", 4'b1000, 4'b0000);
    tick();
    memread = 1'b0;
    tick(2);

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
